// File: rtl/sad_pkg.sv
// Shared definitions for the SAD best-match tracker: FSM state encodings and SAD value constants.
package sad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } sad_state_t;

  localparam int SAD_DATA_W = 32;
  localparam logic [SAD_DATA_W-1:0] SAD_MAX = {SAD_DATA_W{1'b1}};

endpackage

// File: rtl/sad_min_cmp.sv
// Running-minimum register: keeps the smallest SAD accepted so far and the index it arrived at.
module sad_min_cmp
  import sad_pkg::*;
#(
  parameter int DATA_W = SAD_DATA_W,
  parameter int CAND_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] sad_in,
  input  logic [CAND_W-1:0] idx_in,
  output logic [DATA_W-1:0] best_sad,
  output logic [CAND_W-1:0] best_idx
);

  logic [DATA_W-1:0] best_sad_q, best_sad_d;
  logic [CAND_W-1:0] best_idx_q, best_idx_d;

  always_comb begin
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (clear) begin
      best_sad_d = {DATA_W{1'b1}};
      best_idx_d = '0;
    end else if (load && (sad_in < best_sad_q)) begin
      // strict compare: on a tie the earlier candidate wins
      best_sad_d = sad_in;
      best_idx_d = idx_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad_q <= {DATA_W{1'b1}};
      best_idx_q <= '0;
    end else begin
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: rtl/sad_best_match.sv
// Tracks minimum SAD and its candidate index over a search window, pulsing done when complete.
// Optional threshold-based early termination is enabled by defining SAD_EARLY_EXIT_EN.
module sad_best_match
  import sad_pkg::*;
#(
  parameter int DATA_W = SAD_DATA_W,
  parameter int CAND_W = 8
) (
  input  logic              clk,
  input  logic              Mrst_n,
  input  logic              start,
  input  logic [CAND_W-1:0] num_cand,
  input  logic              sad_valid,
  input  logic [DATA_W-1:0] sad_in,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [DATA_W-1:0] exit_thresh,
  output logic              early_exit,
`endif
  output logic              sad_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] best_sad,
  output logic [CAND_W-1:0] best_idx,
  output logic [CAND_W-1:0] cand_cnt
);

  sad_state_t        state_q, state_d;
  logic [CAND_W-1:0] num_cand_q, num_cand_d;
  logic [CAND_W-1:0] cand_cnt_q, cand_cnt_d;
  logic              clear;
  logic              accept;
`ifdef SAD_EARLY_EXIT_EN
  logic              early_exit_q, early_exit_d;
`endif

  assign sad_ready = (state_q == ST_TRACK);
  assign busy      = (state_q == ST_TRACK);
  assign done      = (state_q == ST_DONE);
  assign accept    = sad_valid & sad_ready;

  always_comb begin
    state_d    = state_q;
    num_cand_d = num_cand_q;
    cand_cnt_d = cand_cnt_q;
    clear      = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
    early_exit_d = early_exit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_cand_d = num_cand;
          cand_cnt_d = '0;
          clear      = 1'b1;
`ifdef SAD_EARLY_EXIT_EN
          early_exit_d = 1'b0;
`endif
          state_d    = (num_cand == '0) ? ST_DONE : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept) begin
          cand_cnt_d = cand_cnt_q + CAND_W'(1);
          if (cand_cnt_q == num_cand_q - CAND_W'(1)) begin
            state_d = ST_DONE;
          end
`ifdef SAD_EARLY_EXIT_EN
          if (sad_in <= exit_thresh) begin
            early_exit_d = 1'b1;
            state_d      = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Mrst_n) begin
      state_q    <= ST_IDLE;
      num_cand_q <= '0;
      cand_cnt_q <= '0;
`ifdef SAD_EARLY_EXIT_EN
      early_exit_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      num_cand_q <= num_cand_d;
      cand_cnt_q <= cand_cnt_d;
`ifdef SAD_EARLY_EXIT_EN
      early_exit_q <= early_exit_d;
`endif
    end
  end

  sad_min_cmp #(
    .DATA_W (DATA_W),
    .CAND_W (CAND_W)
  ) u_min_cmp (
    .clk      (clk),
    .rst_n    (Mrst_n),
    .clear    (clear),
    .load     (accept),
    .sad_in   (sad_in),
    .idx_in   (cand_cnt_q),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

  assign cand_cnt = cand_cnt_q;
`ifdef SAD_EARLY_EXIT_EN
  assign early_exit = early_exit_q;
`endif

endmodule

// File: tb/tb_sad_best_match.sv
// Self-checking bench for sad_best_match: per-cycle comparison against a list-based search model
// plus directed scenarios with hand-computed results.
module tb_sad_best_match;
  import sad_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          mrst_n;
  logic          start;
  logic [CW-1:0] num_cand;
  logic          sad_valid;
  logic [DW-1:0] sad_in;
  logic          sad_ready, busy, done;
  logic [DW-1:0] best_sad;
  logic [CW-1:0] best_idx, cand_cnt;
`ifdef SAD_EARLY_EXIT_EN
  logic [DW-1:0] exit_thresh;
  logic          early_exit;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  sad_best_match #(.DATA_W(DW), .CAND_W(CW)) dut (
    .clk        (clk),
    .Mrst_n     (mrst_n),
    .start      (start),
    .num_cand   (num_cand),
    .sad_valid  (sad_valid),
    .sad_in     (sad_in),
`ifdef SAD_EARLY_EXIT_EN
    .exit_thresh(exit_thresh),
    .early_exit (early_exit),
`endif
    .sad_ready  (sad_ready),
    .busy       (busy),
    .done       (done),
    .best_sad   (best_sad),
    .best_idx   (best_idx),
    .cand_cnt   (cand_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=searching 2=finished; accepted samples kept as a list.
  int            m_phase = 0;
  int            m_ncand = 0;
  bit            m_ee = 0;
  logic [DW-1:0] acc[$];

  always @(posedge clk) begin
    if (!mrst_n) begin
      m_phase = 0; m_ncand = 0; m_ee = 0; acc.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
             m_ncand = int'(num_cand); m_ee = 0; acc.delete();
             m_phase = (num_cand == 0) ? 2 : 1;
           end
        1: if (sad_valid) begin
             acc.push_back(sad_in);
             if (acc.size() == m_ncand) m_phase = 2;
`ifdef SAD_EARLY_EXIT_EN
             if (sad_in <= exit_thresh) begin m_ee = 1; m_phase = 2; end
`endif
           end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [DW-1:0] model_best_sad();
    logic [DW-1:0] b = SAD_MAX;
    foreach (acc[i]) if (acc[i] < b) b = acc[i];
    return b;
  endfunction

  function automatic logic [CW-1:0] model_best_idx();
    logic [DW-1:0] b = SAD_MAX;
    int k = 0;
    foreach (acc[i]) if (acc[i] < b) begin b = acc[i]; k = i; end
    return CW'(k);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",      busy,      m_phase == 1);
      check("model_sad_ready", sad_ready, m_phase == 1);
      check("model_done",      done,      m_phase == 2);
      check("model_best_sad",  best_sad,  model_best_sad());
      check("model_best_idx",  best_idx,  model_best_idx());
      check("model_cand_cnt",  cand_cnt,  acc.size());
`ifdef SAD_EARLY_EXIT_EN
      check("model_early_exit", early_exit, m_ee);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_cand = CW'(n);
    tick();
    start = 1'b0; num_cand = '0;
  endtask

  task automatic send(input logic [DW-1:0] v, input int gap);
    sad_valid = 1'b1; sad_in = v;
    tick();
    sad_valid = 1'b0; sad_in = '0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic wait_done(input string name, input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, lim);
    end
    $display("txn %s: best_sad=%0h best_idx=%0d cand_cnt=%0d", name, best_sad, best_idx, cand_cnt);
  endtask

  initial begin
    mrst_n = 1'b0; start = 1'b0; num_cand = '0; sad_valid = 1'b0; sad_in = '0;
`ifdef SAD_EARLY_EXIT_EN
    exit_thresh = '0;
`endif
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    check("reset_best_sad", best_sad, 32'hFFFF_FFFF);
    check("reset_busy", busy, 1'b0);
    check("reset_cand_cnt", cand_cnt, 8'd0);
    mrst_n = 1'b1;
    tick();

    // 1: basic search with a tie on the minimum
    do_start(4);
    send(50, 0); send(20, 0); send(35, 0); send(20, 0);
    wait_done("t1", 5);
    check("t1_best_sad", best_sad, 32'd20);
    check("t1_best_idx", best_idx, 8'd1);
    check("t1_cand_cnt", cand_cnt, 8'd4);
    tick(); tick();

    // 2: empty search
    do_start(0);
    wait_done("t2", 3);
    check("t2_best_sad", best_sad, 32'hFFFF_FFFF);
    check("t2_best_idx", best_idx, 8'd0);
    tick(); tick();

    // 3: reset mid-search, then a fresh search
    do_start(5);
    send(30, 0); send(40, 0);
    mrst_n = 1'b0;
    tick();
    mrst_n = 1'b1;
    @(negedge clk);
    check("t3_rst_best_sad", best_sad, 32'hFFFF_FFFF);
    check("t3_rst_cand_cnt", cand_cnt, 8'd0);
    check("t3_rst_busy", busy, 1'b0);
    tick();
    do_start(2);
    send(9, 0); send(3, 0);
    wait_done("t3", 4);
    check("t3_best_sad", best_sad, 32'd3);
    check("t3_best_idx", best_idx, 8'd1);
    tick(); tick();

    // 4: start during search ignored, sad_valid in idle dropped
    do_start(3);
    send(5, 0);
    start = 1'b1; num_cand = 8'd0;
    send(6, 0);
    start = 1'b0;
    send(7, 0);
    wait_done("t4", 4);
    sad_valid = 1'b1; sad_in = 32'd1;
    tick(); tick(); tick();
    sad_valid = 1'b0; sad_in = '0;
    @(negedge clk);
    check("t4_best_sad", best_sad, 32'd5);
    check("t4_best_idx", best_idx, 8'd0);
    check("t4_cand_cnt", cand_cnt, 8'd3);
    tick();

    // 6: gapped valid, one sample every 3 cycles
    do_start(3);
    send(100, 2); send(100, 2); send(99, 0);
    wait_done("t6", 4);
    check("t6_best_sad", best_sad, 32'd99);
    check("t6_best_idx", best_idx, 8'd2);
    tick(); tick();

`ifdef SAD_EARLY_EXIT_EN
    // 5: early termination on threshold
    exit_thresh = 32'd10;
    do_start(8);
    send(40, 0); send(7, 0);
    wait_done("t5", 3);
    check("t5_best_sad", best_sad, 32'd7);
    check("t5_best_idx", best_idx, 8'd1);
    check("t5_early_exit", early_exit, 1'b1);
    check("t5_cand_cnt", cand_cnt, 8'd2);
    tick(); tick();
    exit_thresh = '0;
`endif

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
